decode_stage: RTL and testbench

//  ID stage of the 5-stage RV32I pipeline, directly downstream of fetch. Consumes instrD/PCD,

---
 rtl/decode_stage_pkg.sv | 113 +++++++++++
 rtl/decode_stage_reg_file.sv | 42 ++++
 rtl/decode_stage.sv | 180 ++++++++++++++++++
 tb/tb_decode_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage: opcodes, ALU op and
// result-source encodings, immediate formats, control and ID/EX bundles.
package rv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4,
    IMM_U    = 3'd5
  } imm_type_e;

  // Decoded control for one instruction; all-zero is a NOP
  typedef struct packed {
    logic      reg_write;
    logic      mem_write;
    res_src_e  result_src;
    logic      branch;
    logic      jump;
    logic      alu_src_a;
    logic      alu_src_b;
    alu_op_e   alu_ctrl;
    imm_type_e imm_type;
    logic      rs1_zero;   // LUI: read x0 instead of instr[19:15]
  } ctrl_t;

  // Contents of the ID/EX pipeline register; all-zero is a bubble
  typedef struct packed {
    logic                  reg_write;
    logic                  mem_write;
    res_src_e              result_src;
    logic                  branch;
    logic                  jump;
    logic                  alu_src_a;
    logic                  alu_src_b;
    alu_op_e               alu_ctrl;
    logic [2:0]            funct3;
    logic [XLEN-1:0]       rd1;
    logic [XLEN-1:0]       rd2;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       pc_plus4;
  } idex_t;

  // Sign-extended immediate for the given instruction format
  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] i, input imm_type_e t);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (t)
      IMM_I:   imm = {{20{i[31]}}, i[31:20]};
      IMM_S:   imm = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_U:   imm = {i[31:12], 12'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // ALU op from funct3; alt selects SUB/SRA where the encoding allows it
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_reg_file.sv
// 32 x XLEN register file, two combinational read ports and one write port.
// x0 always reads zero; a read of the register being written this cycle
// returns the write data so the decode stage never latches a stale value.
module reg_file
  import rv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ra1_i,
  input  logic [REG_ADDR_W-1:0] ra2_i,
  output logic [XLEN-1:0]       rd1_o,
  output logic [XLEN-1:0]       rd2_o,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] wa_i,
  input  logic [XLEN-1:0]       wd_i
);

  logic [XLEN-1:0] regs_q [32];
  logic            wr_en;

  assign wr_en = we_i && (wa_i != '0);

  // Register array: async clear, writes to x0 dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Read ports with x0 forcing and write-through bypass
  always_comb begin
    rd1_o = regs_q[ra1_i];
    rd2_o = regs_q[ra2_i];
    if (ra1_i == '0)                 rd1_o = '0;
    else if (wr_en && wa_i == ra1_i) rd1_o = wd_i;
    if (ra2_i == '0)                 rd2_o = '0;
    else if (wr_en && wa_i == ra2_i) rd2_o = wd_i;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decodes instrD, builds the immediate, reads the register
// file and registers the result into the ID/EX pipeline register.
// Unknown opcodes decode to an all-zero NOP; flushE inserts a bubble.
module decode_stage
  import rv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instrD,
  input  logic [XLEN-1:0]       PCD,
  input  logic                  flushE,
  input  logic                  regWriteW,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic [XLEN-1:0]       resultW,
  output logic                  regWriteE,
  output logic                  memWriteE,
  output logic [1:0]            resultSrcE,
  output logic                  branchE,
  output logic                  jumpE,
  output logic                  ALUsrcAE,
  output logic                  ALUsrcBE,
  output logic [3:0]            ALUctrlE,
  output logic [2:0]            funct3E,
  output logic [XLEN-1:0]       RD1E,
  output logic [XLEN-1:0]       RD2E,
  output logic [XLEN-1:0]       immE,
  output logic [REG_ADDR_W-1:0] rs1E,
  output logic [REG_ADDR_W-1:0] rs2E,
  output logic [REG_ADDR_W-1:0] rdE,
  output logic [XLEN-1:0]       PCE,
  output logic [XLEN-1:0]       PCplus4E
);

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic                  funct7_5;
  ctrl_t                 ctrl;
  logic [REG_ADDR_W-1:0] rs1_idx;
  logic [REG_ADDR_W-1:0] rs2_idx;
  logic [XLEN-1:0]       rd1;
  logic [XLEN-1:0]       rd2;
  idex_t                 idex_d;
  idex_t                 idex_q;

  assign opcode   = instrD[6:0];
  assign funct3   = instrD[14:12];
  assign funct7_5 = instrD[30];

  // Main control decode from the opcode
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = alu_from_f3(funct3, funct7_5);
      end
      OP_I_ALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_type  = IMM_I;
        // funct7[5] is part of the immediate except for shift-right
        ctrl.alu_ctrl  = alu_from_f3(funct3, (funct3 == 3'b101) && funct7_5);
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src_b  = 1'b1;
        ctrl.imm_type   = IMM_I;
        ctrl.alu_ctrl   = ALU_ADD;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_type  = IMM_S;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.imm_type = IMM_B;
        ctrl.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.imm_type   = IMM_J;
        ctrl.alu_ctrl   = ALU_ADD;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
        ctrl.alu_src_b  = 1'b1;
        ctrl.imm_type   = IMM_I;
        ctrl.alu_ctrl   = ALU_ADD;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_type  = IMM_U;
        ctrl.alu_ctrl  = ALU_ADD;
        ctrl.rs1_zero  = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.imm_type  = IMM_U;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      default: ctrl = '0;
    endcase
  end

  // LUI adds its immediate to x0, so rs1 is redirected there
  assign rs1_idx = ctrl.rs1_zero ? '0 : instrD[19:15];
  assign rs2_idx = instrD[24:20];

  reg_file u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (rs1_idx),
    .ra2_i (rs2_idx),
    .rd1_o (rd1),
    .rd2_o (rd2),
    .we_i  (regWriteW),
    .wa_i  (rdW),
    .wd_i  (resultW)
  );

  // Assemble the next ID/EX contents
  always_comb begin
    idex_d            = '0;
    idex_d.reg_write  = ctrl.reg_write;
    idex_d.mem_write  = ctrl.mem_write;
    idex_d.result_src = ctrl.result_src;
    idex_d.branch     = ctrl.branch;
    idex_d.jump       = ctrl.jump;
    idex_d.alu_src_a  = ctrl.alu_src_a;
    idex_d.alu_src_b  = ctrl.alu_src_b;
    idex_d.alu_ctrl   = ctrl.alu_ctrl;
    idex_d.funct3     = funct3;
    idex_d.rd1        = rd1;
    idex_d.rd2        = rd2;
    idex_d.imm        = imm_gen(instrD, ctrl.imm_type);
    idex_d.rs1        = rs1_idx;
    idex_d.rs2        = rs2_idx;
    idex_d.rd         = instrD[11:7];
    idex_d.pc         = PCD;
    idex_d.pc_plus4   = PCD + 32'd4;
  end

  // ID/EX register: async reset and sync flush both load a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         idex_q <= '0;
    else if (flushE) idex_q <= '0;
    else             idex_q <= idex_d;
  end

  assign regWriteE  = idex_q.reg_write;
  assign memWriteE  = idex_q.mem_write;
  assign resultSrcE = idex_q.result_src;
  assign branchE    = idex_q.branch;
  assign jumpE      = idex_q.jump;
  assign ALUsrcAE   = idex_q.alu_src_a;
  assign ALUsrcBE   = idex_q.alu_src_b;
  assign ALUctrlE   = idex_q.alu_ctrl;
  assign funct3E    = idex_q.funct3;
  assign RD1E       = idex_q.rd1;
  assign RD2E       = idex_q.rd2;
  assign immE       = idex_q.imm;
  assign rs1E       = idex_q.rs1;
  assign rs2E       = idex_q.rs2;
  assign rdE        = idex_q.rd;
  assign PCE        = idex_q.pc;
  assign PCplus4E   = idex_q.pc_plus4;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded instructions with
// hand-computed control, immediate and operand values.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic        flushE;
  logic        regWriteW;
  logic [4:0]  rdW;
  logic [31:0] resultW;
  logic        regWriteE;
  logic        memWriteE;
  logic [1:0]  resultSrcE;
  logic        branchE;
  logic        jumpE;
  logic        ALUsrcAE;
  logic        ALUsrcBE;
  logic [3:0]  ALUctrlE;
  logic [2:0]  funct3E;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] immE;
  logic [4:0]  rs1E;
  logic [4:0]  rs2E;
  logic [4:0]  rdE;
  logic [31:0] PCE;
  logic [31:0] PCplus4E;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk        (clk),
    .rst        (rst),
    .instrD     (instrD),
    .PCD        (PCD),
    .flushE     (flushE),
    .regWriteW  (regWriteW),
    .rdW        (rdW),
    .resultW    (resultW),
    .regWriteE  (regWriteE),
    .memWriteE  (memWriteE),
    .resultSrcE (resultSrcE),
    .branchE    (branchE),
    .jumpE      (jumpE),
    .ALUsrcAE   (ALUsrcAE),
    .ALUsrcBE   (ALUsrcBE),
    .ALUctrlE   (ALUctrlE),
    .funct3E    (funct3E),
    .RD1E       (RD1E),
    .RD2E       (RD2E),
    .immE       (immE),
    .rs1E       (rs1E),
    .rs2E       (rs2E),
    .rdE        (rdE),
    .PCE        (PCE),
    .PCplus4E   (PCplus4E)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // One clock: outputs settle and are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    instrD = instr;
    PCD    = pc;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    regWriteW = we;
    rdW       = rd;
    resultW   = data;
  endtask

  initial begin
    rst = 1'b1;
    drive(32'h0, 32'h0);
    flushE = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    repeat (2) step();
    check("rst_regwrite", {31'b0, regWriteE}, 32'h0);
    check("rst_imm", immE, 32'h0);
    check("rst_pc", PCE, 32'h0);
    check("rst_pc4", PCplus4E, 32'h0);
    rst = 1'b0;

    // WB x5 and read it the same cycle via add x6,x5,x0
    drive(32'h00028333, 32'h40);
    wb(1'b1, 5'd5, 32'hDEADBEEF);
    step();
    check("bypass_rd1", RD1E, 32'hDEADBEEF);
    check("add_rs1", {27'b0, rs1E}, 32'd5);
    check("add_rd", {27'b0, rdE}, 32'd6);
    check("add_regwrite", {31'b0, regWriteE}, 32'h1);
    check("add_aluctrl", {28'b0, ALUctrlE}, 32'd0);
    check("add_srcb", {31'b0, ALUsrcBE}, 32'h0);
    check("add_pc", PCE, 32'h40);
    check("add_pc4", PCplus4E, 32'h44);

    // Write to x0 is dropped, read of x0 is zero
    drive(32'h00000333, 32'h44);
    wb(1'b1, 5'd0, 32'h00001234);
    step();
    check("x0_read", RD1E, 32'h0);

    // x5 still holds its value; x31 written with bypass on port 2
    drive(32'h01F28333, 32'h48);
    wb(1'b1, 5'd31, 32'hCAFEF00D);
    step();
    check("x5_kept", RD1E, 32'hDEADBEEF);
    check("bypass_rd2", RD2E, 32'hCAFEF00D);

    // beq x0,x0,-4 ; meanwhile x8 written
    drive(32'hFE000EE3, 32'h200);
    wb(1'b1, 5'd8, 32'hAAAA5555);
    step();
    check("beq_imm", immE, 32'hFFFFFFFC);
    check("beq_branch", {31'b0, branchE}, 32'h1);
    check("beq_aluctrl", {28'b0, ALUctrlE}, 32'd1);
    check("beq_regwrite", {31'b0, regWriteE}, 32'h0);
    check("beq_srcb", {31'b0, ALUsrcBE}, 32'h0);
    wb(1'b0, 5'd0, 32'h0);

    // lui x3,0x12345: raw rs1 field is x8, must read x0 instead
    drive(32'h123451B7, 32'h204);
    step();
    check("lui_imm", immE, 32'h12345000);
    check("lui_rd1", RD1E, 32'h0);
    check("lui_rs1", {27'b0, rs1E}, 32'd0);
    check("lui_srca", {31'b0, ALUsrcAE}, 32'h0);
    check("lui_srcb", {31'b0, ALUsrcBE}, 32'h1);
    check("lui_regwrite", {31'b0, regWriteE}, 32'h1);

    // auipc x10,1
    drive(32'h00001517, 32'h208);
    step();
    check("auipc_imm", immE, 32'h00001000);
    check("auipc_srca", {31'b0, ALUsrcAE}, 32'h1);

    // srai x7,x5,3
    drive(32'h4032D393, 32'h20C);
    step();
    check("srai_aluctrl", {28'b0, ALUctrlE}, 32'd7);
    check("srai_imm", immE, 32'h00000403);
    check("srai_rd1", RD1E, 32'hDEADBEEF);

    // sub x1,x2,x3
    drive(32'h403100B3, 32'h210);
    step();
    check("sub_aluctrl", {28'b0, ALUctrlE}, 32'd1);

    // lw x4,-4(x2)
    drive(32'hFFC12203, 32'h214);
    step();
    check("lw_imm", immE, 32'hFFFFFFFC);
    check("lw_ressrc", {30'b0, resultSrcE}, 32'd1);
    check("lw_funct3", {29'b0, funct3E}, 32'd2);
    check("lw_srcb", {31'b0, ALUsrcBE}, 32'h1);

    // sw x2,8(x1)
    drive(32'h0020A423, 32'h218);
    step();
    check("sw_imm", immE, 32'h8);
    check("sw_memwrite", {31'b0, memWriteE}, 32'h1);
    check("sw_srcb", {31'b0, ALUsrcBE}, 32'h1);
    check("sw_regwrite", {31'b0, regWriteE}, 32'h0);
    check("sw_rd", {27'b0, rdE}, 32'd8);

    // Same store with flushE: bubble, but WB of x9 still lands
    flushE = 1'b1;
    wb(1'b1, 5'd9, 32'h00000099);
    step();
    check("flush_memwrite", {31'b0, memWriteE}, 32'h0);
    check("flush_imm", immE, 32'h0);
    check("flush_rs1", {27'b0, rs1E}, 32'd0);
    check("flush_pc", PCE, 32'h0);
    flushE = 1'b0;
    wb(1'b0, 5'd0, 32'h0);

    // add x6,x9,x0 reads the value written during the flush
    drive(32'h00048333, 32'h21C);
    step();
    check("flush_wb_rd1", RD1E, 32'h00000099);

    // jal x1,+2048 at 0x100
    drive(32'h001000EF, 32'h100);
    step();
    check("jal_jump", {31'b0, jumpE}, 32'h1);
    check("jal_ressrc", {30'b0, resultSrcE}, 32'd2);
    check("jal_pc4", PCplus4E, 32'h104);
    check("jal_imm", immE, 32'h800);
    check("jal_srca", {31'b0, ALUsrcAE}, 32'h1);
    check("jal_regwrite", {31'b0, regWriteE}, 32'h1);

    // Undefined opcode decodes as NOP
    drive(32'h0000007F, 32'h300);
    step();
    check("bad_regwrite", {31'b0, regWriteE}, 32'h0);
    check("bad_memwrite", {31'b0, memWriteE}, 32'h0);
    check("bad_jump_branch", {30'b0, jumpE, branchE}, 32'h0);
    check("bad_aluctrl", {28'b0, ALUctrlE}, 32'd0);
    check("bad_pc", PCE, 32'h300);

    // Mid-stream async reset with a jal in ID/EX
    drive(32'h001000EF, 32'h100);
    step();
    check("pre_rst_jump", {31'b0, jumpE}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_jump", {31'b0, jumpE}, 32'h0);
    check("async_rst_pc4", PCplus4E, 32'h0);
    check("async_rst_regwrite", {31'b0, regWriteE}, 32'h0);
    step();
    rst = 1'b0;

    // Registers cleared: x5 and x31 read 0
    drive(32'h01F28333, 32'h400);
    step();
    check("post_rst_x5", RD1E, 32'h0);
    check("post_rst_x31", RD2E, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
